// File: rtl/sync_pkg.sv
// ============================================================================
// Module      : sync_pkg
// Description : Shared limits and helpers for the signal synchroniser/debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int DEB_MAX    = 65535;
    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 32;

    // Bits needed to hold 0..debCycles; never less than one bit.
    function automatic int cntWidth(input int debCycles);
        int w;
        w = $clog2(debCycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_debounce_ch.sv
// ============================================================================
// Module      : sync_debounce_ch
// Description : One channel: metastability chain, debounce counter, edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter int   DEB_CYCLES = 16,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic accept_o
);

    localparam int                 c_CNT_W    = cntWidth(DEB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", keep = "true" *)
    logic [STAGES-1:0]  r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;
    logic               w_s;
    logic               w_accept;

    assign w_s      = r_sync[STAGES-1];
    // High on the cycle whose edge commits a new level; lets the top register
    // its summary flag alongside the per-channel pulses.
    assign w_accept = (w_s != r_level) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], sig_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level <= RESET_VAL;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= w_s;
                r_cnt   <= '0;
                r_rise  <= w_s;
                r_fall  <= ~w_s;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign level_o  = r_level;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign accept_o = w_accept;

endmodule

`default_nettype wire

// File: rtl/signal_sync_debounce.sv
// ============================================================================
// Module      : signal_sync_debounce
// Description : WIDTH independent synchronise-and-debounce channels with pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_sync_debounce
    import sync_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               STAGES     = 2,
    parameter int               DEB_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             any_change_o
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_badWidth
        $error("signal_sync_debounce: WIDTH out of range 1..32");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_badStages
        $error("signal_sync_debounce: STAGES out of range 2..4");
    end
    if (DEB_CYCLES < 1 || DEB_CYCLES > DEB_MAX) begin : g_badDeb
        $error("signal_sync_debounce: DEB_CYCLES out of range 1..65535");
    end

    logic [WIDTH-1:0] w_accept;
    logic             r_anyChange;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_debounce_ch #(
            .STAGES     (STAGES),
            .DEB_CYCLES (DEB_CYCLES),
            .RESET_VAL  (RESET_VAL[i])
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .sig_i    (sig_i[i]),
            .level_o  (level_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i]),
            .accept_o (w_accept[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_anyChange <= 1'b0;
        end else begin
            r_anyChange <= |w_accept;
        end
    end

    assign any_change_o = r_anyChange;

endmodule

`default_nettype wire

// File: tb/tb_signal_sync_debounce.sv
// ============================================================================
// Module      : tb_signal_sync_debounce
// Description : Self-checking bench with a history-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signal_sync_debounce;

    localparam int W   = 4;
    localparam int STG = 2;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sig;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         anyChg;

    int checks   = 0;
    int failures = 0;

    // Reference model: a level flips once the last DEB synchronised samples all
    // disagree with it; the synchronised sample is the input seen STG edges ago.
    logic [W-1:0] mLevel, mRise, mFall;
    logic         mAny;
    logic [W-1:0] sampQ[$];
    logic [W-1:0] sQ[$];

    signal_sync_debounce #(
        .WIDTH      (W),
        .STAGES     (STG),
        .DEB_CYCLES (DEB),
        .RESET_VAL  ('0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_i        (sig),
        .level_o      (level),
        .rise_o       (rise),
        .fall_o       (fall),
        .any_change_o (anyChg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        logic [W-1:0] sPre;
        logic [W-1:0] acc;
        logic         ok;
        @(posedge clk);
        if (!rst_n) begin
            mLevel = '0; mRise = '0; mFall = '0; mAny = 1'b0;
            sampQ  = {};
            for (int k = 0; k < STG; k++) sampQ.push_back('0);
            sQ = {};
        end else begin
            sPre = sampQ[sampQ.size() - STG];
            sampQ.push_back(sig);
            if (sampQ.size() > 8) void'(sampQ.pop_front());
            sQ.push_back(sPre);
            if (sQ.size() > 16) void'(sQ.pop_front());
            acc = '0;
            for (int n = 0; n < W; n++) begin
                ok = (sQ.size() >= DEB);
                for (int j = 0; j < DEB && ok; j++)
                    if (sQ[sQ.size() - 1 - j][n] == mLevel[n]) ok = 1'b0;
                acc[n] = ok;
            end
            mRise  = acc & ~mLevel;
            mFall  = acc & mLevel;
            mLevel = mLevel ^ acc;
            mAny   = |acc;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sig = '0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sig = 4'hF;
        step(); step();
        checks++;
        if (level !== 4'h0) begin failures++; $display("FAIL reset_level: got %h want 0", level); end
        checks++;
        if ({rise, fall, anyChg} !== 9'h0) begin
            failures++; $display("FAIL reset_pulses: rise=%h fall=%h any=%b want 0", rise, fall, anyChg);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 5) begin
                checks++;
                if (level !== 4'h0) begin failures++; $display("FAIL reset_early: edge5 level=%h want 0", level); end
            end
            if (e == 6) begin
                checks++;
                if (level !== 4'hF || rise !== 4'hF || fall !== 4'h0 || anyChg !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_accept: level=%h rise=%h fall=%h any=%b want F F 0 1", level, rise, fall, anyChg);
                end
            end
            if (e == 7) begin
                checks++;
                if (rise !== 4'h0 || anyChg !== 1'b0) begin
                    failures++; $display("FAIL reset_pulse_len: rise=%h any=%b want 0 0", rise, anyChg);
                end
            end
        end
    endtask

    task automatic test_clean_step();
        int lat;
        do_reset();
        repeat (3) step();
        sig[0] = 1'b1;
        lat = 0;
        for (int e = 1; e <= 20 && lat == 0; e++) begin
            step();
            if (level[0]) begin
                lat = e;
                checks++;
                if (rise !== 4'h1 || anyChg !== 1'b1) begin
                    failures++; $display("FAIL step_pulse: rise=%h any=%b want 1 1", rise, anyChg);
                end
            end
        end
        checks++;
        if (lat != STG + DEB) begin failures++; $display("FAIL step_latency: got %0d want %0d (0=timeout)", lat, STG + DEB); end
        step();
        checks++;
        if (rise !== 4'h0 || level[0] !== 1'b1) begin
            failures++; $display("FAIL step_one_cycle: rise=%h level=%h want 0, bit0=1", rise, level);
        end
    endtask

    task automatic test_glitch();
        int seen;
        int rises;
        do_reset();
        sig[1] = 1'b1;
        repeat (3) step();
        sig[1] = 1'b0;
        seen = 0;
        repeat (12) begin
            step();
            if (rise[1] || level[1] || anyChg) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL glitch_reject: %0d active cycles want 0", seen); end
        sig[1] = 1'b1;
        rises = 0;
        repeat (4) begin step(); if (rise[1]) rises++; end
        sig[1] = 1'b0;
        repeat (12) begin step(); if (rise[1]) rises++; end
        checks++;
        if (rises != 1) begin failures++; $display("FAIL glitch_accept4: rises=%0d want 1", rises); end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        int rises;
        int riseEdge;
        do_reset();
        pat = 5'b10101;
        rises = 0; riseEdge = 0;
        for (int e = 1; e <= 20; e++) begin
            if (e <= 5) sig[2] = pat[e-1];
            step();
            if (rise[2]) begin rises++; riseEdge = e; end
        end
        checks++;
        if (rises != 1 || riseEdge != 10) begin
            failures++; $display("FAIL bounce: rises=%0d at edge %0d want 1 at 10", rises, riseEdge);
        end
    endtask

    task automatic test_simultaneous();
        logic got;
        do_reset();
        sig = 4'h5;
        got = 1'b0;
        for (int e = 0; e < 20 && !got; e++) begin
            step();
            if (rise != 4'h0 || fall != 4'h0) begin
                got = 1'b1;
                checks++;
                if (rise !== 4'h5 || fall !== 4'h0) begin
                    failures++; $display("FAIL simul_rise: rise=%h fall=%h want 5 0", rise, fall);
                end
            end
        end
        if (!got) begin checks++; failures++; $display("FAIL simul_rise: timeout, no pulse"); end
        sig = 4'hA;
        got = 1'b0;
        for (int e = 0; e < 20 && !got; e++) begin
            step();
            if (rise != 4'h0 || fall != 4'h0) begin
                got = 1'b1;
                checks++;
                if (rise !== 4'hA || fall !== 4'h5 || anyChg !== 1'b1) begin
                    failures++; $display("FAIL simul_swap: rise=%h fall=%h any=%b want A 5 1", rise, fall, anyChg);
                end
            end
        end
        if (!got) begin checks++; failures++; $display("FAIL simul_swap: timeout, no pulse"); end
    endtask

    task automatic test_reset_mid_count();
        int lat;
        do_reset();
        sig = 4'h8;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (level !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || anyChg !== 1'b0) begin
            failures++;
            $display("FAIL midreset: level=%h rise=%h fall=%h any=%b want 0", level, rise, fall, anyChg);
        end
        rst_n = 1'b1;
        lat = 0;
        for (int e = 1; e <= 20 && lat == 0; e++) begin
            step();
            if (level[3]) begin
                lat = e;
                checks++;
                if (rise !== 4'h8) begin failures++; $display("FAIL midreset_pulse: rise=%h want 8", rise); end
            end
        end
        checks++;
        if (lat != STG + DEB) begin failures++; $display("FAIL midreset_latency: got %0d want %0d", lat, STG + DEB); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) sig = sig ^ W'($urandom);
            rst_n = ($urandom_range(0, 150) != 0);
            step();
            checks++;
            if (level !== mLevel || rise !== mRise || fall !== mFall || anyChg !== mAny) begin
                failures++;
                $display("FAIL random[%0d]: level=%h rise=%h fall=%h any=%b want %h %h %h %b",
                         i, level, rise, fall, anyChg, mLevel, mRise, mFall, mAny);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        sig   = '0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
